// File: rtl/scan_mux.sv
// Registered N-to-1 channel multiplexer with a manual select mode and a
// dwell-timed round-robin scan mode; out, ch and new_ch are all registered.
`timescale 1ns/1ps
module scan_mux #(
  parameter int N      = 7,
  parameter int W      = 1,
  parameter int DIV    = 4,
  parameter int SW_SEL = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in,
  input  logic [SW_SEL-1:0] sel,
  input  logic              mode,
  input  logic              hold,
  output logic [W-1:0]      out,
  output logic [SW_SEL-1:0] ch,
  output logic              new_ch
);

  localparam int                CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [SW_SEL-1:0] CH_LAST  = SW_SEL'(N - 1);
  localparam logic [SW_SEL:0]   N_EXT    = (SW_SEL + 1)'(N);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [SW_SEL-1:0] r_ch;
  logic [SW_SEL-1:0] r_last_ch;
  logic [W-1:0]      r_out;
  logic              r_new_ch;

  logic              w_sel_ok;
  logic [SW_SEL-1:0] w_sel_ch;
  logic [W-1:0]      w_ch_data;

  // Out-of-range manual selects fall back to channel 0.
  always_comb begin
    w_sel_ok = ({1'b0, sel} < N_EXT);
    if (w_sel_ok) begin
      w_sel_ch = sel;
    end else begin
      w_sel_ch = '0;
    end
  end

  // Channel data mux driven by the registered channel index.
  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < N; k++) begin
      if (r_ch == SW_SEL'(k)) begin
        w_ch_data = in[k*W +: W];
      end else begin
        w_ch_data = w_ch_data;
      end
    end
  end

  // Mode FSM, dwell sequencer and registered datapath. Dropping mode acts
  // on the very next edge, so a SCAN cycle with mode=0 already loads sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_MANUAL;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_last_ch <= '0;
      r_out     <= '0;
      r_new_ch  <= 1'b0;
    end else begin
      r_state   <= mode ? ST_SCAN : ST_MANUAL;
      r_out     <= w_ch_data;
      r_last_ch <= r_ch;
      r_new_ch  <= (r_ch != r_last_ch);
      case (r_state)
        ST_SCAN: begin
          if (!mode) begin
            r_ch  <= w_sel_ch;
            r_cnt <= '0;
          end else if (hold) begin
            r_ch  <= r_ch;
            r_cnt <= r_cnt;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_ch  <= (r_ch == CH_LAST) ? '0 : r_ch + SW_SEL'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_MANUAL: begin
          r_ch  <= w_sel_ch;
          r_cnt <= '0;
        end
        default: begin
          r_ch  <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign out    = r_out;
  assign ch     = r_ch;
  assign new_ch = r_new_ch;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: three instances cover the N/W/DIV combinations
// exercised (7x1 div4, 7x4 div4, 5x8 div1).
`timescale 1ns/1ps
module tb_scan_mux;

  logic clk;
  logic reset;

  logic [6:0]  in0;
  logic [2:0]  sel0;
  logic        mode0, hold0;
  logic [0:0]  out0;
  logic [2:0]  ch0;
  logic        nch0;

  logic [27:0] in1;
  logic [2:0]  sel1;
  logic        mode1, hold1;
  logic [3:0]  out1;
  logic [2:0]  ch1;
  logic        nch1;

  logic [39:0] in2;
  logic [2:0]  sel2;
  logic        mode2, hold2;
  logic [7:0]  out2;
  logic [2:0]  ch2;
  logic        nch2;

  int n_checks;
  int n_err;
  int pulses;
  bit found;

  scan_mux #(.N(7), .W(1), .DIV(4)) u0 (
    .clk(clk), .reset(reset), .in(in0), .sel(sel0), .mode(mode0), .hold(hold0),
    .out(out0), .ch(ch0), .new_ch(nch0)
  );

  scan_mux #(.N(7), .W(4), .DIV(4)) u1 (
    .clk(clk), .reset(reset), .in(in1), .sel(sel1), .mode(mode1), .hold(hold1),
    .out(out1), .ch(ch1), .new_ch(nch1)
  );

  scan_mux #(.N(5), .W(8), .DIV(1)) u2 (
    .clk(clk), .reset(reset), .in(in2), .sel(sel2), .mode(mode2), .hold(hold2),
    .out(out2), .ch(ch2), .new_ch(nch2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    pulses   = 0;
    found    = 1'b0;
    reset    = 1'b1;
    in0 = 7'b1000000; sel0 = 3'd0; mode0 = 1'b0; hold0 = 1'b0;
    in1 = 28'd0;      sel1 = 3'd0; mode1 = 1'b0; hold1 = 1'b0;
    in2 = 40'd0;      sel2 = 3'd0; mode2 = 1'b0; hold2 = 1'b0;
    for (int k = 0; k < 7; k++) in1[k*4 +: 4] = 4'(k + 3);
    for (int k = 0; k < 5; k++) in2[k*8 +: 8] = 8'(8'h10 + k);

    #2;
    check("rst_out", 32'(out0), 32'd0);
    check("rst_ch", 32'(ch0), 32'd0);
    check("rst_new_ch", 32'(nch0), 32'd0);

    // Manual select, then out-of-range select
    @(negedge clk);
    reset = 1'b0;
    sel0  = 3'd6;
    step(1);
    check("man_ch6", 32'(ch0), 32'd6);
    check("man_out_lag", 32'(out0), 32'd0);
    check("man_nch_lag", 32'(nch0), 32'd0);
    step(1);
    check("man_out6", 32'(out0), 32'd1);
    check("man_nch_pulse", 32'(nch0), 32'd1);
    step(1);
    check("man_nch_end", 32'(nch0), 32'd0);
    sel0 = 3'd7;
    step(1);
    check("oor_ch0", 32'(ch0), 32'd0);
    check("oor_out_lag", 32'(out0), 32'd1);
    step(1);
    check("oor_out0", 32'(out0), 32'd0);
    check("oor_nch", 32'(nch0), 32'd1);

    // Live data on a fixed manual channel
    sel0 = 3'd4;
    step(3);
    check("live_ch4", 32'(ch0), 32'd4);
    check("live_nch_idle", 32'(nch0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in0[4] = ~in0[4];
      step(1);
      check("live_out", 32'(out0), 32'(in0[4]));
      check("live_nch", 32'(nch0), 32'd0);
    end

    // Scan wrap on the 4-bit instance, then hold at ch=2 / cnt=3
    mode1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      check("scan_ch", 32'(ch1), 32'(((i - 1) / 4) % 7));
      check("scan_out", 32'(out1), (i == 1) ? 32'd3 : 32'(((i - 2) / 4) % 7 + 3));
      if (i >= 3 && i <= 30 && nch1) pulses++;
    end
    check("scan_pulses", 32'(pulses), 32'd7);
    hold1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_ch", 32'(ch1), 32'd2);
      check("hold_nch", 32'(nch1), 32'd0);
    end
    hold1 = 1'b0;
    step(1);
    check("hold_release_ch", 32'(ch1), 32'd3);
    step(1);
    check("hold_release_nch", 32'(nch1), 32'd1);
    check("hold_release_out", 32'(out1), 32'd6);

    // Reset mid-scan at ch=5, then restart with a full dwell on ch 0
    in0   = 7'b1111111;
    sel0  = 3'd0;
    mode0 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ch0 == 3'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_ch5", 32'(found), 32'd1);
    step(1);
    check("pre_rst_nch", 32'(nch0), 32'd1);
    check("pre_rst_out", 32'(out0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out0), 32'd0);
    check("async_rst_ch", 32'(ch0), 32'd0);
    check("async_rst_nch", 32'(nch0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("restart_ch0", 32'(ch0), 32'd0);
    end
    step(1);
    check("restart_ch1", 32'(ch0), 32'd1);

    // Mode switching with DIV=1
    mode2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("div1_scan_ch", 32'(ch2), 32'(i));
    end
    mode2 = 1'b0;
    sel2  = 3'd1;
    step(1);
    check("to_manual_ch", 32'(ch2), 32'd1);
    mode2 = 1'b1;
    step(1);
    check("to_scan_ch", 32'(ch2), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      step(1);
      check("div1_adv_ch", 32'(ch2), 32'(i % 5));
    end
    check("div1_out", 32'(out2), 32'h14);
    mode2 = 1'b0;
    sel2  = 3'd3;
    step(1);
    check("u2_man_ch3", 32'(ch2), 32'd3);
    sel2 = 3'd5;
    step(1);
    check("u2_oor_ch0", 32'(ch2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
